// File: rtl/float_pkg.sv
// Shared sequencer state encoding and IEEE-754 single-precision constants.
// Used by the accumulator and by sibling tops that drive the same cores.
package float_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_IN   = 3'd1,
    FUNC_WAIT = 3'd2,
    ADD_WAIT  = 3'd3,
    FINISH    = 3'd4
  } state_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_HALF = 32'h3F00_0000;
  localparam logic [31:0] FP_128  = 32'h4300_0000;

endpackage

// File: rtl/core_watchdog.sv
// Per-wait cycle counter: cleared on entry to a core wait, counts while enabled and
// flags expiry on the TIMEOUT-th waiting cycle. TIMEOUT = 0 never expires.
module core_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LIMIT = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expired = (TIMEOUT != 0) && i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/func_accumulator.sv
// Streams up to MAX_N samples through an external function core and sums the results
// with an external adder; one sample accepted per WAIT_IN visit, each core wait is watchdogged.
module func_accumulator
  import float_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MAX_N   = 16,
  parameter int CNT_W   = $clog2(MAX_N + 1),
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              func_start,
  output logic [DATA_W-1:0] func_data,
  input  logic [DATA_W-1:0] func_result,
  input  logic              func_done,
  output logic              add_start,
  output logic [DATA_W-1:0] add_dataa,
  output logic [DATA_W-1:0] add_datab,
  input  logic [DATA_W-1:0] add_result,
  input  logic              add_done,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy,
  output logic              error
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_func_data;
  logic [DATA_W-1:0] r_add_dataa;
  logic [DATA_W-1:0] r_add_datab;
  logic              r_done;
  logic              r_error;
  logic              r_busy;
  logic              r_in_ready;
  logic              r_func_start;
  logic              r_add_start;

  logic [CNT_W-1:0]  w_count_clamp;
  logic              w_last;
  logic              w_wd_clr;
  logic              w_wd_en;
  logic              w_wd_expired;

  assign w_count_clamp = (count > CNT_W'(MAX_N)) ? CNT_W'(MAX_N) : count;
  assign w_last        = (r_idx + CNT_W'(1)) == r_count;
  assign w_wd_en       = (r_state == FUNC_WAIT) || (r_state == ADD_WAIT);
  // Clear on the edges that enter a wait state, so the first waiting cycle sees zero.
  assign w_wd_clr      = ((r_state == WAIT_IN) && in_valid) ||
                         ((r_state == FUNC_WAIT) && func_done && (r_idx != '0));

  core_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_idx        <= '0;
      r_acc        <= '0;
      r_result     <= '0;
      r_func_data  <= '0;
      r_add_dataa  <= '0;
      r_add_datab  <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_busy       <= 1'b0;
      r_in_ready   <= 1'b0;
      r_func_start <= 1'b0;
      r_add_start  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_count <= w_count_clamp;
            r_idx   <= '0;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            if (w_count_clamp == '0) begin
              r_acc    <= FP_ZERO;
              r_result <= FP_ZERO;
              r_done   <= 1'b1;
              r_state  <= FINISH;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= WAIT_IN;
            end
          end
        end
        WAIT_IN: begin
          if (in_valid) begin
            r_func_data  <= in_data;
            r_in_ready   <= 1'b0;
            r_func_start <= 1'b1;
            r_state      <= FUNC_WAIT;
          end
        end
        FUNC_WAIT: begin
          if (func_done) begin
            r_func_start <= 1'b0;
            if (r_idx == '0) begin
              // First element seeds the accumulator directly; no add is needed.
              r_acc <= func_result;
              r_idx <= r_idx + CNT_W'(1);
              if (w_last) begin
                r_result <= func_result;
                r_done   <= 1'b1;
                r_state  <= FINISH;
              end else begin
                r_in_ready <= 1'b1;
                r_state    <= WAIT_IN;
              end
            end else begin
              r_add_dataa <= r_acc;
              r_add_datab <= func_result;
              r_add_start <= 1'b1;
              r_state     <= ADD_WAIT;
            end
          end else if (w_wd_expired) begin
            r_func_start <= 1'b0;
            r_error      <= 1'b1;
            r_result     <= FP_QNAN;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        ADD_WAIT: begin
          if (add_done) begin
            r_add_start <= 1'b0;
            r_acc       <= add_result;
            r_idx       <= r_idx + CNT_W'(1);
            if (w_last) begin
              r_result <= add_result;
              r_done   <= 1'b1;
              r_state  <= FINISH;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= WAIT_IN;
            end
          end else if (w_wd_expired) begin
            r_add_start <= 1'b0;
            r_error     <= 1'b1;
            r_result    <= FP_QNAN;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        FINISH: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign func_start = r_func_start;
  assign func_data  = r_func_data;
  assign add_start  = r_add_start;
  assign add_dataa  = r_add_dataa;
  assign add_datab  = r_add_datab;
  assign result     = r_result;
  assign done       = r_done;
  assign busy       = r_busy;
  assign error      = r_error;

endmodule

// File: tb/tb_func_accumulator.sv
// Bench for func_accumulator: integer-valued float stub cores, vector table, corner sequences
// and randomized jobs checked against a summing reference model.
module tb_func_accumulator;

  localparam int DATA_W  = 32;
  localparam int MAX_N   = 16;
  localparam int CNT_W   = $clog2(MAX_N + 1);
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  count = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready, func_start, func_done, add_start, add_done, done, busy, error;
  logic [DATA_W-1:0] func_data, func_result, add_dataa, add_datab, add_result, result;

  always #5 clk = ~clk;

  func_accumulator #(.DATA_W(DATA_W), .MAX_N(MAX_N), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .func_start(func_start), .func_data(func_data), .func_result(func_result), .func_done(func_done),
    .add_start(add_start), .add_dataa(add_dataa), .add_datab(add_datab),
    .add_result(add_result), .add_done(add_done),
    .result(result), .done(done), .busy(busy), .error(error)
  );

  // Non-negative integer <-> float32 conversions (exact below 2^24).
  function automatic int f2i(input logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'd0, 1'b1, f[22:0]};
    if (e < 0) return 0;
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [31:0] i2f(input int v);
    int p;
    logic [31:0] mv;
    if (v == 0) return 32'h0;
    p = 0;
    for (int k = 0; k < 31; k++) if (v[k]) p = k;
    mv = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), mv[22:0]};
  endfunction

  // Function core stand-in: f(128.0) = 16448.0, identity otherwise.
  function automatic logic [31:0] fstub(input logic [31:0] x);
    return (x == 32'h4300_0000) ? 32'h4680_8000 : x;
  endfunction

  int f_lat = 1, a_lat = 1;
  bit f_hang = 0, a_hang = 0;
  int fcnt = 0, acnt = 0;

  always @(posedge clk) begin
    fcnt <= func_start ? fcnt + 1 : 0;
    acnt <= add_start ? acnt + 1 : 0;
  end

  assign func_done   = func_start && !f_hang && (fcnt + 1 >= f_lat);
  assign func_result = fstub(func_data);
  assign add_done    = add_start && !a_hang && (acnt + 1 >= a_lat);
  assign add_result  = i2f(f2i(add_dataa) + f2i(add_datab));

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic [31:0] xq[$];
  logic [31:0] cap[$];
  logic [31:0] sent[$];
  int n_func_cyc, n_add_cyc, n_done, done_cyc;
  logic [31:0] r_res;
  logic r_err;

  task automatic feed(input int c, input bit alt);
    in_valid = (xq.size() > 0) && (!alt || (c % 2 == 0));
    in_data  = (xq.size() > 0) ? xq[0] : 32'h0;
    if (in_valid && in_ready) void'(xq.pop_front());
  endtask

  task automatic run_job(input int n_req, input bit alt, input bit poke);
    bit fs_prev, to;
    fs_prev = 1'b0; to = 1'b1;
    n_func_cyc = 0; n_add_cyc = 0; n_done = 0; done_cyc = -1;
    cap.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (func_start) n_func_cyc++;
      if (func_start && !fs_prev) cap.push_back(func_data);
      fs_prev = func_start;
      if (add_start) n_add_cyc++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
        r_res = result;
        r_err = error;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) begin
        to = 1'b0;
        break;
      end
      start = (c == 0) || (poke && c == 4);
      count = CNT_W'((c == 0) ? n_req : 1);
      feed(c, alt);
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (to) chk("job timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    int          n;
    int          flat;
    int          alat;
    bit          fhang;
    bit          ahang;
    logic [31:0] x;
    logic [31:0] exp_res;
    logic        exp_err;
    int          exp_nf;
  } vec_t;

  vec_t tbl[7];
  bit   seen;
  int   n, sum;
  logic [31:0] x;

  initial begin
    tbl[0] = '{1,  5, 1, 0, 0, 32'h4300_0000, 32'h4680_8000, 1'b0, 1};
    tbl[1] = '{2,  1, 3, 0, 0, 32'h4300_0000, 32'h4700_8000, 1'b0, 2};
    tbl[2] = '{0,  1, 1, 0, 0, 32'h4300_0000, 32'h0000_0000, 1'b0, 0};
    tbl[3] = '{1,  1, 1, 1, 0, 32'h4300_0000, 32'h7FC0_0000, 1'b1, 1};
    tbl[4] = '{3,  8, 8, 0, 0, 32'h4000_0000, 32'h40C0_0000, 1'b0, 3};
    tbl[5] = '{20, 2, 2, 0, 0, 32'h3F80_0000, 32'h4180_0000, 1'b0, 16};
    tbl[6] = '{2,  1, 1, 0, 1, 32'h4000_0000, 32'h7FC0_0000, 1'b1, 2};

    @(negedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset error", error, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset func_start", func_start, 0);
    chk("reset add_start", add_start, 0);
    chk("reset result", result, 0);
    chk("reset func_data", func_data, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      f_lat = tbl[i].flat; a_lat = tbl[i].alat;
      f_hang = tbl[i].fhang; a_hang = tbl[i].ahang;
      xq.delete();
      for (int k = 0; k < tbl[i].n; k++) xq.push_back(tbl[i].x);
      run_job(tbl[i].n, 1'b0, 1'b0);
      chk($sformatf("vec%0d result", i), r_res, tbl[i].exp_res);
      chk($sformatf("vec%0d error", i), r_err, tbl[i].exp_err);
      chk($sformatf("vec%0d samples", i), cap.size(), tbl[i].exp_nf);
      chk($sformatf("vec%0d done pulses", i), n_done, 1);
      if (i == 0) begin
        chk("single func_data", cap.size() > 0 ? cap[0] : 32'hx, 32'h4300_0000);
        chk("single add_start cycles", n_add_cyc, 0);
      end
      if (i == 1) chk("pair add_start cycles", n_add_cyc, 3);
      if (i == 2) begin
        chk("zero done latency", done_cyc, 1);
        chk("zero func_start cycles", n_func_cyc, 0);
      end
      if (i == 3) chk("watchdog func_start cycles", n_func_cyc, 8);
    end
    f_hang = 0; a_hang = 0;

    // Backpressure with 1010 valid pattern and a start pulse while busy.
    f_lat = 2; a_lat = 2;
    xq.delete(); sent.delete();
    for (int k = 0; k < 3; k++) begin
      sent.push_back(i2f(3 + 2 * k));
      xq.push_back(i2f(3 + 2 * k));
    end
    run_job(3, 1'b1, 1'b1);
    chk("bp samples", cap.size(), 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp order %0d", k), k < cap.size() ? cap[k] : 32'hx, sent[k]);
    chk("bp result", r_res, i2f(15));
    chk("bp done pulses", n_done, 1);
    chk("bp start ignored", busy, 0);

    // Reset while waiting on the adder.
    f_lat = 1; a_lat = 1; a_hang = 1; seen = 0;
    xq.delete(); xq.push_back(32'h3F80_0000); xq.push_back(32'h3F80_0000);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (add_start) begin
        seen = 1;
        break;
      end
      start = (c == 0);
      count = CNT_W'(2);
      feed(c, 1'b0);
    end
    start = 1'b0; in_valid = 1'b0;
    chk("reach add wait", seen, 1);
    reset = 1'b1;
    #1;
    chk("mid reset busy", busy, 0);
    chk("mid reset add_start", add_start, 0);
    chk("mid reset result", result, 0);
    chk("mid reset func_start", func_start, 0);
    @(negedge clk);
    reset = 1'b0; a_hang = 0;
    xq.delete(); xq.push_back(32'h4300_0000);
    run_job(1, 1'b0, 1'b0);
    chk("post reset result", r_res, 32'h4680_8000);
    chk("post reset error", r_err, 0);
    chk("post reset done pulses", n_done, 1);

    // Randomized jobs against the summing model.
    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(0, 16);
      f_lat = $urandom_range(1, 8);
      a_lat = $urandom_range(1, 8);
      sum = 0;
      xq.delete(); sent.delete();
      for (int k = 0; k < n; k++) begin
        x = i2f($urandom_range(0, 255));
        xq.push_back(x);
        sent.push_back(x);
        sum += f2i(fstub(x));
      end
      run_job(n, bit'($urandom_range(0, 1)), 1'b0);
      chk($sformatf("rand%0d result", j), r_res, i2f(sum));
      chk($sformatf("rand%0d error", j), r_err, 0);
      chk($sformatf("rand%0d samples", j), cap.size(), n);
      for (int k = 0; k < n; k++)
        chk($sformatf("rand%0d sample %0d", j, k), k < cap.size() ? cap[k] : 32'hx, sent[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/func_accumulator.md
Name: func_accumulator

Overview:
- Sequencer that streams COUNT IEEE-754 single-precision samples through an external function core, e.g. the y = 0.5*x + x^2*cos((x-128)/128) pipeline. It sums the function results through an external float adder.
- Successor to the fixed two-input top: element count is runtime-programmable up to MAX_N, each core wait has a watchdog, and errors are reported.
- Sits between the host data path and the function/adder cores. It talks to both cores through the codebase enable/done handshake.

Parameters:
- DATA_W, 32, float word width; fixed at 32 for single precision.
- MAX_N, 16, maximum elements per job.
- CNT_W, $clog2(MAX_N+1), width of count.
- TIMEOUT, 1024, cycles allowed per core wait; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- count  in  CNT_W  elements in the job; latched on start; values above MAX_N are clamped to MAX_N.
- in_data  in  DATA_W  sample x.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a sample.
- func_start  out  1  enable to the function core; held high until func_done.
- func_data  out  DATA_W  operand to the function core; stable while func_start is high.
- func_result  in  DATA_W  function core result.
- func_done  in  1  function core result valid.
- add_start  out  1  enable to the adder; held high until add_done.
- add_dataa  out  DATA_W  accumulator operand.
- add_datab  out  DATA_W  new function result operand.
- add_result  in  DATA_W  adder result.
- add_done  in  1  adder result valid.
- result  out  DATA_W  sum of f(x_i); held until the next start.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- error  out  1  watchdog fired; sticky until the next accepted start.

Behaviour:
- Reset (async):
  - state = IDLE.
  - result, acc, func_data, add_dataa, add_datab, watchdog counter, element index = 0.
  - done, error, busy, in_ready, func_start, add_start = 0.
- State IDLE:
  - start = 1 → latch count (clamped), clear error and the index, go to WAIT_IN.
  - start = 1 with count = 0 → go to FINISH with acc = 0 (result 0x00000000).
- State WAIT_IN:
  - in_ready = 1.
  - in_valid & in_ready → func_data <= in_data, go to FUNC_WAIT.
  - No timeout applies to input starvation.
- State FUNC_WAIT:
  - func_start = 1.
  - func_done = 1 → capture func_result into f_reg and drop func_start (low on the following cycle).
  - If index = 0: acc <= f_reg and no add is issued.
  - Otherwise: go to ADD_WAIT with add_dataa = acc and add_datab = f_reg.
  - After the index-0 path: last element → FINISH, else WAIT_IN.
- State ADD_WAIT:
  - add_start = 1.
  - add_done = 1 → acc <= add_result, index++.
  - Next state: FINISH if index+1 = count, else WAIT_IN.
- State FINISH:
  - result <= acc, done = 1 for exactly one cycle, then IDLE.
  - Minimum latency with zero-latency cores is 1 (WAIT_IN) + 1 (FUNC) + 1 (ADD) cycles per element, plus 1 cycle for FINISH.
- Watchdog:
  - The counter clears on entry to FUNC_WAIT and to ADD_WAIT.
  - If it reaches TIMEOUT-1 while the awaited done is still low: both enables drop, error = 1, result = 0x7FC00000 (quiet NaN), done pulses, state goes to IDLE.
- start while busy is ignored; there is no queueing.
- A done and a watchdog expiry in the same cycle: done wins, and no error is raised.
- in_valid outside WAIT_IN is ignored; in_ready = 0 there.
- Reset asserted mid-job aborts immediately to the reset values.
- No pending core result is consumed after reset, and the cores see their enable drop asynchronously.
- No float arithmetic is done inside the block: values pass through bit-exact.

Decomposition:
- Shared package float_pkg holds:
  - state enum (IDLE, WAIT_IN, FUNC_WAIT, ADD_WAIT, FINISH).
  - FP_QNAN = 32'h7FC00000 and FP_ZERO.
  - float constants FP_HALF = 32'h3F000000 and FP_128 = 32'h43000000, for reuse by sibling tops.
- One natural sub-module, core_watchdog: a loadable counter with clear, enable and expired outputs, parameterised by TIMEOUT.

Test Plan:
- Single element, function stub latency 5, x = 0x43000000 (128.0):
  - Required: func_data = 0x43000000; result = 0x46808000 (16448.0).
  - done pulses once; add_start never asserts.
- count = 2, both x = 128.0, stub adder latency 3 → result = 0x47008000 (32896.0), add_start high exactly 3 cycles.
- count = 0 → done one cycle after start, result = 0x00000000, func_start never asserts.
- Watchdog, TIMEOUT = 8, func_done never asserted → func_start high 8 cycles, then error = 1, result = 0x7FC00000, done pulse.
- Backpressure and ignored start:
  - in_valid toggled 1010 during a 3-element job → exactly 3 samples are captured, in order.
  - start pulsed while busy → no effect.
- Reset asserted in ADD_WAIT → same cycle: busy = add_start = 0, result = 0. A following job with count = 1 completes normally.
